// File: rtl/fold_accum_pkg.sv
// fold_accum_pkg
//   Shared constants, FSM state type and modular-add helper for the
//   folded-residue accumulator (mod 2^13-1).
//   No ports.
package fold_accum_pkg;

    localparam int DATAWIDTH = 16;     // default stream data width
    localparam int MOD_M     = 8191;   // 2^13 - 1
    localparam int MOD_BITS  = 13;
    localparam int CNT_W     = 8;      // per-block sample count width

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // (a + b) mod M for a, b already in 0..M-1. A 14-bit sum needs at most
    // one subtraction of M to land back in range.
    function automatic logic [MOD_BITS-1:0] mod_add(input logic [MOD_BITS-1:0] a,
                                                    input logic [MOD_BITS-1:0] b);
        logic [MOD_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (MOD_BITS+1)'(MOD_M))
            s = s - (MOD_BITS+1)'(MOD_M);
        return s[MOD_BITS-1:0];
    endfunction

endpackage

// File: rtl/fold_accum_fifo.sv
// fold_accum_fifo
//   Two-entry FIFO holding closed block results.
//   Ports:
//     clk    in      clock
//     reset  in      asynchronous active-low reset
//     push   in      write din this cycle
//     pop    in      remove head this cycle (only meaningful when !empty)
//     din    in  W   entry to write
//     dout   out W   head entry
//     full   out     two entries held
//     empty  out     no entries held
//   A push while full is accepted only if a pop happens in the same cycle;
//   otherwise it is ignored and the contents are left untouched.
module fold_accum_fifo
    import fold_accum_pkg::*;
#(
    parameter int W = MOD_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         wr_en;
    logic         rd_en;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign rd_en = pop && !empty;
    // When full, the write slot is the head slot; it is being read out on
    // this same edge, so overwriting it is safe.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en)
                rd_ptr <= ~rd_ptr;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fold_accum.sv
// fold_accum
//   Sink for the folded-residue stream from the mod-8191 fold stage.
//   Canonicalises each sample to 0..8190, sums blocks of BLK samples mod
//   8191 and queues each block sum in a 2-entry output buffer.
//   Ports:
//     clk        in       clock
//     reset      in       asynchronous active-low reset
//     in_e       in  DW   folded value, legal 0..8194
//     in_rdy     in       sample strobe (no backpressure)
//     flush      in       close the current block early
//     out_data   out DW   head block sum, zero-extended from 13 bits
//     out_valid  out      buffer non-empty
//     out_ready  in       downstream accepts head
//     out_cnt    out 8    sample count of head entry (FOLD_ACCUM_CNT_EN only)
//     overflow   out      sticky: a block sum was dropped on a full buffer
//   Build option: define FOLD_ACCUM_CNT_EN to store and expose per-block
//   sample counts.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ST_IDLE  | no open block, acc = 0, cnt = 0
//   ST_ACCUM | block open, acc/cnt hold the partial sum
module fold_accum
    import fold_accum_pkg::*;
#(
    parameter int DW  = DATAWIDTH,
    parameter int BLK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_e,
    input  logic          in_rdy,
    input  logic          flush,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef FOLD_ACCUM_CNT_EN
    output logic [CNT_W-1:0] out_cnt,
`endif
    output logic          overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK - 1);
`ifdef FOLD_ACCUM_CNT_EN
    localparam int FW = MOD_BITS + CNT_W;
`else
    localparam int FW = MOD_BITS;
`endif

    state_t              state_q, state_d;
    logic [MOD_BITS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MOD_BITS-1:0] canon;
    logic [MOD_BITS-1:0] sum_in;
    logic [MOD_BITS-1:0] close_val;
    logic                close;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [FW-1:0]       fifo_din;
    logic [FW-1:0]       fifo_dout;

    // Legal inputs above M-1 are at most 8194, so subtracting M in the low
    // 13 bits alone is exact; out-of-contract values just wrap harmlessly.
    assign canon  = (in_e >= DW'(MOD_M)) ? (in_e[MOD_BITS-1:0] - MOD_BITS'(MOD_M))
                                         : in_e[MOD_BITS-1:0];
    assign sum_in = mod_add(acc_q, canon);

    // A sample arriving with the closing condition belongs to the closing block.
    assign close_val = in_rdy ? sum_in : acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        close   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_rdy) begin
                    if ((cnt_q == LAST_CNT) || flush) begin
                        close = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                        acc_d   = sum_in;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if ((in_rdy && (cnt_q == LAST_CNT)) || flush) begin
                    close   = 1'b1;
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (in_rdy) begin
                    acc_d = sum_in;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign push = close;
    assign pop  = out_valid && out_ready;

`ifdef FOLD_ACCUM_CNT_EN
    assign fifo_din = {(in_rdy ? cnt_q + CNT_W'(1) : cnt_q), close_val};
    assign out_cnt  = fifo_dout[FW-1:MOD_BITS];
`else
    assign fifo_din = close_val;
`endif

    fold_accum_fifo #(.W(FW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_data  = {{(DW-MOD_BITS){1'b0}}, fifo_dout[MOD_BITS-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (push && full && !pop)
            overflow <= 1'b1;
    end

endmodule

// File: tb/tb_fold_accum.sv
module tb_fold_accum;
    import fold_accum_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] in_e;
    logic        in_rdy;
    logic        flush;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
`ifdef FOLD_ACCUM_CNT_EN
    logic [7:0]  out_cnt;
`endif

    int vectors;
    int miscompares;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    fold_accum #(.DW(16), .BLK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_e      (in_e),
        .in_rdy    (in_rdy),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FOLD_ACCUM_CNT_EN
        .out_cnt   (out_cnt),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every handshake pops one expected entry.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output got=%0d expected=none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.d) begin
                    miscompares++;
                    $display("FAIL block_sum got=%0d expected=%0d", out_data, mon_e.d);
                end
`ifdef FOLD_ACCUM_CNT_EN
                vectors++;
                if (out_cnt !== mon_e.c) begin
                    miscompares++;
                    $display("FAIL block_cnt got=%0d expected=%0d", out_cnt, mon_e.c);
                end
`endif
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic expect_blk(input logic [15:0] d, input logic [7:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic samp(input logic [15:0] e, input logic fl);
        in_e   = e;
        in_rdy = 1'b1;
        flush  = fl;
        @(posedge clk);
        #1;
        in_rdy = 1'b0;
        flush  = 1'b0;
        in_e   = '0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in_e        = '0;
        in_rdy      = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        @(posedge clk);
        #1;

        // Basic block with inputs needing canonicalisation
        expect_blk(16'd8, 8'd4);
        samp(16'd8191, 1'b0);
        samp(16'd8194, 1'b0);
        samp(16'd5,    1'b0);
        samp(16'd0,    1'b0);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_data",  32'(out_data),  32'd8);
        wait_drain("drain_basic");

        // Modular wrap
        expect_blk(16'd8187, 8'd4);
        repeat (4) samp(16'd8190, 1'b0);
        wait_drain("drain_wrap");

        // Flush cases
        expect_blk(16'd30, 8'd2);
        samp(16'd10, 1'b0);
        samp(16'd20, 1'b0);
        flush_only();
        expect_blk(16'd5, 8'd1);
        samp(16'd5, 1'b1);
        wait_drain("drain_flush");
        flush_only();
        repeat (3) @(posedge clk);
        #1;
        check("idle_flush_no_push", 32'(out_valid), 32'd0);

        // Backpressure and overflow
        out_ready = 1'b0;
        expect_blk(16'd4, 8'd4);
        expect_blk(16'd4, 8'd4);
        repeat (12) samp(16'd1, 1'b0);
        check("bp_overflow", 32'(overflow),  32'd1);
        check("bp_valid",    32'(out_valid), 32'd1);
        check("bp_head",     32'(out_data),  32'd4);
        repeat (2) @(posedge clk);
        #1;
        check("bp_head_hold", 32'(out_data), 32'd4);
        out_ready = 1'b1;
        wait_drain("drain_bp");
        check("bp_overflow_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a block
        samp(16'd7, 1'b0);
        samp(16'd7, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("midrst_overflow", 32'(overflow),  32'd0);
        check("midrst_valid",    32'(out_valid), 32'd0);
        expect_blk(16'd4, 8'd4);
        repeat (4) samp(16'd1, 1'b0);
        wait_drain("drain_midrst");
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
